// File: rtl/snn_pkg.sv
// Shared fixed-point constants and driver state encoding
// for the spiking neuron datapath.
package snn_pkg;

    localparam int N_DEF      = 32;
    localparam int Q_DEF      = 16;
    localparam int STEP_DEF   = 8;
    localparam int STEP_W_DEF = 16;

    localparam logic [N_DEF-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [N_DEF-1:0] SAT_MIN = 32'h8000_0000;
    localparam logic [N_DEF-1:0] ONE_Q   = 32'(1) << Q_DEF;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        LATCH,
        PULSE
    } drv_state_t;

endpackage

// File: rtl/fixed_point_mul_sat.sv
// Signed Q-format multiply: full-width product, arithmetic
// shift by Q (floor), then clamp back to N bits.
module fixed_point_mul_sat
    import snn_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] y
);

    localparam logic signed [2*N-1:0] HI =
        {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] LO =
        {{(N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [2*N-1:0] a_x;
    logic signed [2*N-1:0] b_x;
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] shr;

    assign a_x  = $signed({{N{a[N-1]}}, a});
    assign b_x  = $signed({{N{b[N-1]}}, b});
    assign prod = a_x * b_x;
    assign shr  = prod >>> Q;

    always_comb begin
        y = shr[N-1:0];
        if (shr > HI) begin
            y = HI[N-1:0];
        end else if (shr < LO) begin
            y = LO[N-1:0];
        end
    end

endmodule

// File: rtl/synaptic_current_driver.sv
// Accumulates weighted spike events into a decaying current
// and strobes it to the neuron core once per timestep.
module synaptic_current_driver
    import snn_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int Q           = Q_DEF,
    parameter int STEP_CYCLES = STEP_DEF,
    parameter int STEP_W      = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [N-1:0]      decay,
    input  logic [N-1:0]      bias,
    input  logic              spike_valid,
    input  logic [N-1:0]      spike_weight,
    output logic              spike_ready,
    output logic [N-1:0]      i,
    output logic              apply,
    output logic [STEP_W-1:0] step_count
);

    localparam int CW = $clog2(STEP_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);
    localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    drv_state_t state;
    drv_state_t state_nx;

    logic [CW-1:0] cnt;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_dec;

    function automatic logic [N-1:0] sat_add(
        input logic [N-1:0] x,
        input logic [N-1:0] y
    );
        logic [N:0] s;
        s = {x[N-1], x} + {y[N-1], y};
        // Top two bits disagree only on signed overflow
        if (s[N] != s[N-1]) begin
            return s[N] ? MINV : MAXV;
        end
        return s[N-1:0];
    endfunction

    fixed_point_mul_sat #(
        .N(N),
        .Q(Q)
    ) u_decay (
        .a(acc),
        .b(decay),
        .y(acc_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = ACCUM;
            ACCUM:   if (cnt == LAST) state_nx = LATCH;
            LATCH:   state_nx = PULSE;
            PULSE:   state_nx = enable ? ACCUM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        spike_ready = 1'b0;
        apply       = 1'b0;
        unique case (1'b1)
            (state == ACCUM): spike_ready = 1'b1;
            (state == PULSE): apply = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            acc        <= '0;
            i          <= '0;
            step_count <= '0;
        end else begin
            case (state)
                IDLE: cnt <= '0;
                ACCUM: begin
                    cnt <= cnt + 1'b1;
                    if (spike_valid) begin
                        acc <= sat_add(acc, spike_weight);
                    end
                end
                // Both updates see the pre-decay acc
                LATCH: begin
                    i   <= sat_add(acc, bias);
                    acc <= acc_dec;
                end
                PULSE: begin
                    step_count <= step_count + 1'b1;
                    cnt        <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_synaptic_current_driver.sv
// Scoreboard bench for the synaptic current driver with a
// cycle-level reference model and directed step scenarios.
module tb_synaptic_current_driver;

    localparam int SC = 4;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] decay;
    logic [31:0] bias;
    logic        spike_valid;
    logic [31:0] spike_weight;
    logic        spike_ready;
    logic [31:0] i;
    logic        apply;
    logic [15:0] step_count;

    int n_checks = 0;
    int n_fail   = 0;

    int     m_state = 0;
    int     m_cnt   = 0;
    longint m_acc   = 0;
    longint m_i     = 0;
    int     m_sc    = 0;
    int     cyc     = 0;
    bit     started = 0;

    logic [31:0] expq[$];
    int          apply_cyc[$];
    logic [31:0] ws[4];

    synaptic_current_driver #(
        .N(32),
        .Q(16),
        .STEP_CYCLES(SC),
        .STEP_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .decay(decay),
        .bias(bias),
        .spike_valid(spike_valid),
        .spike_weight(spike_weight),
        .spike_ready(spike_ready),
        .i(i),
        .apply(apply),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint sat32(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Reference model, advanced on the same edge as the DUT
    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            m_state = 0;
            m_cnt   = 0;
            m_acc   = 0;
            m_i     = 0;
            m_sc    = 0;
            expq.delete();
        end else begin
            case (m_state)
                0: if (enable) begin
                    m_state = 1;
                    m_cnt   = 0;
                end
                1: begin
                    if (spike_valid) m_acc = sat32(m_acc + sx(spike_weight));
                    if (m_cnt == SC - 1) m_state = 2;
                    else m_cnt++;
                end
                2: begin
                    m_i = sat32(m_acc + sx(bias));
                    expq.push_back(m_i[31:0]);
                    m_acc = sat32((m_acc * sx(decay)) >>> 16);
                    m_state = 3;
                end
                default: begin
                    m_sc    = (m_sc + 1) % 65536;
                    m_state = enable ? 1 : 0;
                    m_cnt   = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready", spike_ready, m_state == 1);
            check("apply", apply, m_state == 3);
            check("step_count", step_count, m_sc);
            check("i_hold", i, m_i[31:0]);
            if (apply) begin
                apply_cyc.push_back(cyc);
                check("sb_size", expq.size(), 1);
                if (expq.size() > 0) check("sb_i", i, expq.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    task automatic wait_pulse();
        int k = 0;
        @(negedge clk);
        while (!apply && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!apply) check("pulse_timeout", apply, 1);
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!spike_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!spike_ready) check("ready_timeout", spike_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n0;
        int s0;
        rst          = 1'b1;
        enable       = 1'b0;
        spike_valid  = 1'b0;
        spike_weight = '0;
        decay        = 32'h0000_8000;
        bias         = 32'h0000_1000;
        tick(3);

        // Reset lands mid-step with a non-zero accumulator
        rst    = 1'b0;
        enable = 1'b1;
        wait_ready();
        spike_valid  = 1'b1;
        spike_weight = 32'h0002_0000;
        tick(1);
        spike_valid = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);
        check("rst_i", i, 0);
        check("rst_apply", apply, 0);
        check("rst_ready", spike_ready, 0);
        check("rst_step_count", step_count, 0);
        rst = 1'b0;
        wait_pulse();
        check("rst_then_bias", i, 32'h0000_1000);

        // Decay train
        bias  = 32'h0;
        decay = 32'h0000_8000;
        do_reset(1);
        wait_ready();
        spike_valid  = 1'b1;
        spike_weight = 32'h0001_0000;
        tick(1);
        spike_valid = 1'b0;
        wait_pulse();
        check("decay0", i, 32'h0001_0000);
        c0 = cyc;
        tick(1);
        check("apply_width", apply, 0);
        wait_pulse();
        check("decay1", i, 32'h0000_8000);
        check("period1", cyc - c0, 6);
        c0 = cyc;
        wait_pulse();
        check("decay2", i, 32'h0000_4000);
        check("period2", cyc - c0, 6);

        // Back-to-back accumulate
        bias  = 32'h0000_1000;
        decay = 32'h0;
        ws[0] = 32'h0000_4000;
        ws[1] = 32'h0000_4000;
        ws[2] = 32'h0000_4000;
        ws[3] = 32'hFFFF_8000;
        do_reset(1);
        wait_ready();
        for (int k = 0; k < 4; k++) begin
            spike_valid  = 1'b1;
            spike_weight = ws[k];
            tick(1);
        end
        spike_valid = 1'b0;
        wait_pulse();
        check("accum", i, 32'h0000_5000);

        // Saturation both ways
        bias  = 32'h0;
        decay = 32'h0001_0000;
        ws[0] = 32'h7FFF_0000;
        ws[1] = 32'h0001_0000;
        ws[2] = 32'h8001_0000;
        ws[3] = 32'hFFFE_0000;
        for (int p = 0; p < 2; p++) begin
            do_reset(1);
            wait_ready();
            for (int k = 0; k < 2; k++) begin
                spike_valid  = 1'b1;
                spike_weight = ws[2*p+k];
                tick(1);
            end
            spike_valid = 1'b0;
            wait_pulse();
            check(p == 0 ? "sat_pos" : "sat_neg", i,
                  p == 0 ? 32'h7FFF_FFFF : 32'h8000_0000);
        end

        // Over-unity decay saturates the retained current
        decay = 32'h0002_0000;
        wait_pulse();
        wait_pulse();
        check("decay_gt1", i, 32'h8000_0000);

        // Backpressure across LATCH/PULSE
        decay = 32'h0;
        do_reset(1);
        wait_pulse();
        tick(5);
        spike_valid  = 1'b1;
        spike_weight = 32'h0000_3000;
        check("bp_latch_ready", spike_ready, 0);
        tick(1);
        check("bp_pulse_ready", spike_ready, 0);
        check("bp_pulse_apply", apply, 1);
        tick(1);
        check("bp_accum_ready", spike_ready, 1);
        tick(1);
        spike_valid = 1'b0;
        wait_pulse();
        check("bp_once", i, 32'h0000_3000);

        // Enable dropped mid-step
        wait_pulse();
        tick(2);
        enable = 1'b0;
        n0 = apply_cyc.size();
        s0 = m_sc;
        tick(12);
        check("drop_pulses", apply_cyc.size() - n0, 1);
        check("drop_idle", spike_ready, 0);
        check("drop_sc", step_count, (s0 + 1) % 65536);
        enable = 1'b1;
        c0 = cyc;
        tick(1);
        check("restart_ready", spike_ready, 1);
        wait_pulse();
        check("restart_lat", cyc - c0, 6);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
